mlp_score_argmax: RTL and testbench

Downstream consumer of the MLP classifier. On each MLP `done` it captures the packed class scores and the expected label, then scans the scores sequentially, one compare per cycle, to find the winning class. It reports the prediction as an index and as a one-hot vector, and keeps running correct/total counters so the bench or a top level can read accuracy over a batch directly.

---
 rtl/mlp_score_argmax.sv | 153 +++++++++++++++
 tb/tb_mlp_score_argmax.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_score_argmax.sv
// Argmax over packed MLP class scores, one compare per cycle, with running correct/total counters.
// Label checking and correct_cnt exist only when MLP_ARGMAX_LABEL_CHECK_EN is defined.
module mlp_score_argmax #(
  parameter int N_CLASS = 10,
  parameter int SCORE_W = 8,
  parameter int CNT_W   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         done_in,
  input  logic [N_CLASS*SCORE_W-1:0]   ans_in,
  input  logic [3:0]                   label_in,
  input  logic                         clear,
  output logic                         busy,
  output logic                         valid,
  output logic [3:0]                   pred_class,
  output logic [N_CLASS-1:0]           pred_onehot,
  output logic [SCORE_W-1:0]           pred_score,
  output logic [CNT_W-1:0]             correct_cnt,
  output logic [CNT_W-1:0]             total_cnt,
  output logic                         overrun
);
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  localparam logic [3:0]         LAST_IDX = 4'(N_CLASS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [N_CLASS-1:0] ONEHOT0  = N_CLASS'(1);

  state_t                      r_state, w_next;
  logic [N_CLASS*SCORE_W-1:0]  r_scores;
  logic signed [SCORE_W-1:0]   r_best;
  logic [3:0]                  r_best_idx, r_i;
  logic                        r_valid, r_overrun;
  logic [3:0]                  r_pred_class;
  logic [N_CLASS-1:0]          r_pred_onehot;
  logic [SCORE_W-1:0]          r_pred_score;
  logic [CNT_W-1:0]            r_total;
  logic                        w_accept, w_last;
  logic signed [SCORE_W-1:0]   w_cand, w_best;
  logic [3:0]                  w_best_idx;

  assign w_cand = r_scores[r_i*SCORE_W +: SCORE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    w_best     = r_best;
    w_best_idx = r_best_idx;
    case (r_state)
      IDLE, REPORT: begin
        if (done_in) begin
          w_accept = 1'b1;
          w_next   = SCAN;
        end else begin
          w_next   = IDLE;
        end
      end
      SCAN: begin
        // Strict compare: an equal later score never displaces the lower index.
        if (w_cand > r_best) begin
          w_best     = w_cand;
          w_best_idx = r_i;
        end
        if (r_i == LAST_IDX) begin
          w_last = 1'b1;
          w_next = REPORT;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scores      <= '0;
      r_best        <= '0;
      r_best_idx    <= '0;
      r_i           <= '0;
      r_valid       <= 1'b0;
      r_pred_class  <= '0;
      r_pred_onehot <= ONEHOT0;
      r_pred_score  <= '0;
    end else begin
      r_valid <= w_last;
      if (w_accept) begin
        r_scores   <= ans_in;
        r_best     <= ans_in[SCORE_W-1:0];
        r_best_idx <= '0;
        r_i        <= 4'd1;
      end else if (r_state == SCAN) begin
        r_best     <= w_best;
        r_best_idx <= w_best_idx;
        r_i        <= r_i + 4'd1;
      end
      if (w_last) begin
        r_pred_class  <= w_best_idx;
        r_pred_onehot <= ONEHOT0 << w_best_idx;
        r_pred_score  <= w_best;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total   <= '0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_total   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_last && r_total != CNT_MAX) r_total <= r_total + 1'b1;
      if (done_in && r_state == SCAN)   r_overrun <= 1'b1;
    end
  end

`ifdef MLP_ARGMAX_LABEL_CHECK_EN
  logic [3:0]       r_label;
  logic [CNT_W-1:0] r_correct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_label   <= '0;
      r_correct <= '0;
    end else begin
      if (w_accept) r_label <= label_in;
      if (clear)
        r_correct <= '0;
      else if (w_last && r_label == w_best_idx && r_correct != CNT_MAX)
        r_correct <= r_correct + 1'b1;
    end
  end

  assign correct_cnt = r_correct;
`else
  logic w_unused_label;
  assign w_unused_label = ^label_in;
  assign correct_cnt    = '0;
`endif

  assign busy        = (r_state == SCAN);
  assign valid       = r_valid;
  assign pred_class  = r_pred_class;
  assign pred_onehot = r_pred_onehot;
  assign pred_score  = r_pred_score;
  assign total_cnt   = r_total;
  assign overrun     = r_overrun;
endmodule

// File: tb/tb_mlp_score_argmax.sv
// Self-checking bench for mlp_score_argmax: table vectors, hand sequences and randomized samples vs an argmax model.
module tb_mlp_score_argmax;
  localparam int N    = 10;
  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef MLP_ARGMAX_LABEL_CHECK_EN
  localparam bit LABEL_EN = 1'b1;
`else
  localparam bit LABEL_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n, done_in, clear;
  logic [N*W-1:0] ans_in;
  logic [3:0]     label_in;
  logic           busy, valid, overrun;
  logic [3:0]     pred_class;
  logic [N-1:0]   pred_onehot;
  logic [W-1:0]   pred_score;
  logic [CW-1:0]  correct_cnt, total_cnt;

  mlp_score_argmax #(.N_CLASS(N), .SCORE_W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .done_in(done_in), .ans_in(ans_in), .label_in(label_in),
    .clear(clear), .busy(busy), .valid(valid), .pred_class(pred_class),
    .pred_onehot(pred_onehot), .pred_score(pred_score), .correct_cnt(correct_cnt),
    .total_cnt(total_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vseen = 0;
  int t0 = 0;
  int m_total = 0;
  int m_correct = 0;
  int m_overrun = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid === 1'b1) vseen <= vseen + 1;

  typedef struct packed {
    logic [N*W-1:0] ans;
    logic [3:0]     lbl;
    logic [3:0]     exp_cls;
    logic [W-1:0]   exp_score;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] fill(input int v);
    logic [N*W-1:0] a;
    for (int k = 0; k < N; k++) a[k*W +: W] = W'(v);
    return a;
  endfunction

  function automatic logic [N*W-1:0] rand_ans();
    logic [N*W-1:0] a;
    for (int k = 0; k < N; k++) a[k*W +: W] = W'($urandom_range(0, 255));
    return a;
  endfunction

  function automatic int ref_argmax(input logic [N*W-1:0] a);
    int b = 0;
    for (int k = 1; k < N; k++)
      if ($signed(a[k*W +: W]) > $signed(a[b*W +: W])) b = k;
    return b;
  endfunction

  task automatic send(input logic [N*W-1:0] a, input int lbl);
    ans_in   = a;
    label_in = 4'(lbl);
    done_in  = 1'b1;
    tick();
    done_in  = 1'b0;
    t0       = cyc;
  endtask

  task automatic wait_valid();
    while (valid !== 1'b1 && (cyc - t0) < 30) tick();
  endtask

  task automatic check_report(input logic [N*W-1:0] a, input int lbl);
    int b;
    logic [W-1:0] s;
    b = ref_argmax(a);
    s = a[b*W +: W];
    if (m_total < CMAX) m_total++;
    if (LABEL_EN && lbl == b && m_correct < CMAX) m_correct++;
    chk("latency", 32'(cyc - t0), 32'(N - 1));
    chk("valid", 32'(valid), 32'd1);
    chk("pred_class", 32'(pred_class), 32'(b));
    chk("pred_onehot", 32'(pred_onehot), 32'(1) << b);
    chk("pred_score", 32'(pred_score), 32'(s));
    chk("total_cnt", 32'(total_cnt), 32'(m_total));
    chk("correct_cnt", 32'(correct_cnt), 32'(m_correct));
  endtask

  task automatic do_sample(input logic [N*W-1:0] a, input int lbl);
    send(a, lbl);
    wait_valid();
    check_report(a, lbl);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_total = 0;
    m_correct = 0;
    m_overrun = 0;
  endtask

  vec_t           vecs[4];
  logic [N*W-1:0] a, b2;
  int             lbl, v0;

  initial begin
    rst_n = 1'b0; done_in = 1'b0; clear = 1'b0; ans_in = '0; label_in = '0;

    // reset with done_in toggling: nothing may escape
    for (int k = 0; k < 6; k++) begin
      ans_in  = rand_ans();
      done_in = ~done_in;
      tick();
    end
    done_in = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid_seen", 32'(vseen), 32'd0);
    chk("rst_pred_class", 32'(pred_class), 32'd0);
    chk("rst_pred_onehot", 32'(pred_onehot), 32'd1);
    chk("rst_pred_score", 32'(pred_score), 32'd0);
    chk("rst_total", 32'(total_cnt), 32'd0);
    chk("rst_correct", 32'(correct_cnt), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_after_rst", 32'(busy), 32'd0);

    // table: single sample, signed tie, all-equal, winner at last index
    a = fill(0);  a[0*W +: W] = W'(-5); a[3*W +: W] = W'(40); a[7*W +: W] = W'(12);
    vecs[0] = '{ans: a, lbl: 4'd3, exp_cls: 4'd3, exp_score: W'(40)};
    a = fill(-128); a[2*W +: W] = W'(-1); a[6*W +: W] = W'(-1);
    vecs[1] = '{ans: a, lbl: 4'd6, exp_cls: 4'd2, exp_score: W'(-1)};
    a = fill(7);
    vecs[2] = '{ans: a, lbl: 4'd0, exp_cls: 4'd0, exp_score: W'(7)};
    a = fill(-128); a[0*W +: W] = W'(126); a[9*W +: W] = W'(127);
    vecs[3] = '{ans: a, lbl: 4'd9, exp_cls: 4'd9, exp_score: W'(127)};
    for (int k = 0; k < 4; k++) begin
      do_sample(vecs[k].ans, int'(vecs[k].lbl));
      chk("tbl_class", 32'(pred_class), 32'(vecs[k].exp_cls));
      chk("tbl_score", 32'(pred_score), 32'(vecs[k].exp_score));
      tick();
      chk("valid_one_cycle", 32'(valid), 32'd0);
      chk("busy_after_report", 32'(busy), 32'd0);
    end

    // back-to-back: second done_in lands in the REPORT cycle
    do_clear();
    chk("clear_total", 32'(total_cnt), 32'd0);
    a = rand_ans();
    do_sample(a, 1);
    b2 = rand_ans();
    do_sample(b2, ref_argmax(b2));
    chk("b2b_overrun", 32'(overrun), 32'd0);
    tick(); tick();

    // overrun: done_in three cycles into a scan is dropped
    a = rand_ans();
    send(a, 0);
    while ((cyc - t0) < 3) tick();
    ans_in = ~a; done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("overrun_busy", 32'(busy), 32'd1);
    wait_valid();
    check_report(a, 0);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_total", 32'(total_cnt), 32'd3);
    tick();
    chk("overrun_idle", 32'(busy), 32'd0);

    // saturation with randomized samples
    do_clear();
    for (int k = 0; k < 20; k++) begin
      a = rand_ans();
      if ($urandom_range(0, 3) == 0) a[9*W +: W] = a[ref_argmax(a)*W +: W];
      lbl = ($urandom_range(0, 1) == 1) ? ref_argmax(a) : int'($urandom_range(0, 15));
      do_sample(a, lbl);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    chk("sat_total", 32'(total_cnt), 32'(CMAX));

    // clear coincident with the edge entering REPORT
    tick();
    a = rand_ans();
    send(a, ref_argmax(a));
    tick();
    ans_in = rand_ans(); done_in = 1'b1;
    tick();
    done_in = 1'b0;
    while ((cyc - t0) < N - 2) tick();
    chk("pre_clear_overrun", 32'(overrun), 32'd1);
    chk("pre_clear_total", 32'(total_cnt), 32'(m_total));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_valid", 32'(valid), 32'd1);
    chk("clr_pred_class", 32'(pred_class), 32'(ref_argmax(a)));
    chk("clr_pred_score", 32'(pred_score), 32'(a[ref_argmax(a)*W +: W]));
    chk("clr_total", 32'(total_cnt), 32'd0);
    chk("clr_correct", 32'(correct_cnt), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'd0);
    m_total = 0; m_correct = 0;
    tick();

    // reset four cycles into a scan
    a = rand_ans();
    do_sample(a, ref_argmax(a));
    tick();
    send(rand_ans(), 0);
    while ((cyc - t0) < 4) tick();
    v0 = vseen;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_total", 32'(total_cnt), 32'd0);
    chk("mid_rst_onehot", 32'(pred_onehot), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    chk("mid_rst_no_valid", 32'(vseen - v0), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);
    chk("mid_rst_correct", 32'(correct_cnt), 32'd0);
    m_total = 0; m_correct = 0;

    for (int k = 0; k < 3; k++) begin
      a = rand_ans();
      do_sample(a, ref_argmax(a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
